// File: rtl/mul_div_seq_pkg.sv
// Shared types and constants for the mul_div_seq iterative multiply/divide unit.
// Build option DIV_ZERO_EN (used by the interface and top) enables the divide-by-zero fast path.
package mul_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    // Iteration counter must be able to hold the value WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mul_div_seq_if.sv
// Operation bus between a requester and mul_div_seq.
// ERR exists only when DIV_ZERO_EN is defined.
//
// Handshake: the requester raises START for one cycle; it is taken on any edge
// where BUSY is low (IDLE or FIN), together with MODE/A/B. A START seen while
// BUSY is high is dropped. DONE pulses for one cycle when RESULT becomes valid,
// and RESULT stays stable until the next completion or reset.
interface mul_div_seq_if #(parameter int WIDTH = 4);

    logic                 START;
    logic                 MODE;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 BUSY;
    logic                 DONE;
    logic [2*WIDTH-1:0]   RESULT;
`ifdef DIV_ZERO_EN
    logic                 ERR;

    modport master (output START, MODE, A, B, input BUSY, DONE, RESULT, ERR);
    modport slave  (input START, MODE, A, B, output BUSY, DONE, RESULT, ERR);
`else
    modport master (output START, MODE, A, B, input BUSY, DONE, RESULT);
    modport slave  (input START, MODE, A, B, output BUSY, DONE, RESULT);
`endif

endinterface

// File: rtl/mul_div_seq_addsub_row.sv
// One row of ripple full adders; SUB turns it into A - B via A + ~B + 1.
// full_adder is the shared single-bit arithmetic cell of the array datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module addsub_row #(parameter int WIDTH = 4) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH:0] carry;

    assign carry[0] = sub;
    assign cout     = carry[WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder u_fa (
            .a   (a[i]),
            .b   (b[i] ^ sub),
            .cin (carry[i]),
            .sum (sum[i]),
            .cout(carry[i+1])
        );
    end
endmodule

// File: rtl/mul_div_seq.sv
// Iterative unsigned multiply (shift-add) / restoring divide over one adder row.
// Define DIV_ZERO_EN to finish divide-by-zero in one cycle with ERR raised.
module mul_div_seq
    import mul_div_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic          CLK,
    input  logic          RST,
    mul_div_seq_if.slave  bus,
    output state_t        dbg_state
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

    state_t               state;
    state_t               state_next;
    logic                 mode_reg;
    logic [WIDTH-1:0]     b_reg;
    logic [WIDTH-1:0]     acc;
    logic [WIDTH-1:0]     q;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_inc;
    logic [2*WIDTH-1:0]   result;
    logic                 accept;
    logic                 div0;
    logic                 last_iter;

    logic [WIDTH-1:0]     row_a;
    logic [WIDTH-1:0]     row_b;
    logic [WIDTH-1:0]     row_sum;
    logic                 row_cout;
    logic                 ge;
    logic [WIDTH-1:0]     acc_n;
    logic [WIDTH-1:0]     q_n;

    assign accept    = bus.START && (state != RUN);
    assign cnt_inc   = cnt + CNT_W'(1);
    assign last_iter = (cnt_inc == CNT_LAST);

`ifdef DIV_ZERO_EN
    assign div0 = (bus.MODE == MODE_DIV) && (bus.B == '0);
`else
    assign div0 = 1'b0;
`endif

    // Divide feeds the row with {r, q} already shifted left by one.
    assign row_a = (mode_reg == MODE_DIV) ? {acc[WIDTH-2:0], q[WIDTH-1]} : acc;
    assign row_b = (mode_reg == MODE_DIV || q[0]) ? b_reg : '0;

    addsub_row #(.WIDTH(WIDTH)) u_row (
        .a   (row_a),
        .b   (row_b),
        .sub (mode_reg),
        .sum (row_sum),
        .cout(row_cout)
    );

    always_comb begin
        ge    = 1'b0;
        acc_n = acc;
        q_n   = q;
        if (mode_reg == MODE_DIV) begin
            // The bit shifted out of r means the shifted value exceeds any divisor.
            ge    = row_cout | acc[WIDTH-1];
            acc_n = ge ? row_sum : row_a;
            q_n   = {q[WIDTH-2:0], ge};
        end else begin
            acc_n = {row_cout, row_sum[WIDTH-1:1]};
            q_n   = {row_sum[0], q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.START) state_next = div0 ? FIN : RUN;
            RUN:     if (last_iter) state_next = FIN;
            FIN:     if (bus.START) state_next = div0 ? FIN : RUN;
                     else           state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            mode_reg <= MODE_MUL;
            b_reg    <= '0;
            acc      <= '0;
            q        <= '0;
            cnt      <= '0;
            result   <= '0;
        end else if (accept) begin
            mode_reg <= bus.MODE;
            b_reg    <= bus.B;
            acc      <= '0;
            q        <= bus.A;
            cnt      <= '0;
            if (div0) result <= {bus.A, {WIDTH{1'b1}}};
        end else if (state == RUN) begin
            acc <= acc_n;
            q   <= q_n;
            cnt <= cnt_inc;
            if (last_iter) result <= {acc_n, q_n};
        end
    end

`ifdef DIV_ZERO_EN
    logic err;

    always_ff @(posedge CLK) begin
        if (RST)         err <= 1'b0;
        else if (accept) err <= div0;
    end

    assign bus.ERR = err;
`endif

    assign bus.BUSY   = (state == RUN);
    assign bus.DONE   = (state == FIN);
    assign bus.RESULT = result;
    assign dbg_state  = state;

endmodule

// File: tb/tb_mul_div_seq.sv
// Self-checking bench for mul_div_seq (WIDTH = 4): directed plan cases, control
// corner cases and random operations against an arithmetic reference model.
module tb_mul_div_seq;
    import mul_div_pkg::*;

    localparam int W = 4;

    logic   CLK;
    logic   RST;
    state_t dbg_state;

    mul_div_seq_if #(.WIDTH(W)) bus ();

    mul_div_seq #(.WIDTH(W)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .bus      (bus),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- scoreboard ----------------
    logic [2*W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic; divide by zero gives {A, all-ones}.
    function automatic logic [2*W-1:0] model(input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] rem;
        logic [W-1:0] quo;
        if (m == 1'b0) return (2*W)'(a) * (2*W)'(b);
        if (b == '0) return {a, {W{1'b1}}};
        rem = a % b;
        quo = a / b;
        return {rem, quo};
    endfunction

    function automatic bit fast_div0(input logic m, input logic [W-1:0] b);
`ifdef DIV_ZERO_EN
        return (m == 1'b1) && (b == '0);
`else
        return 1'b0;
`endif
    endfunction

    // ---------------- driver tasks ----------------
    // All tasks run and return 1 time unit after a rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Issues one operation and waits for DONE. disturb pulses START with other
    // operands two cycles into RUN; the unit must ignore it.
    task automatic run_op(input logic m, input logic [W-1:0] a, input logic [W-1:0] b, input bit disturb);
        int  lat;
        int  busy_cycles;
        bit  fast;
        logic [2*W-1:0] exp;
        fast = fast_div0(m, b);
        exp_q.push_back(model(m, a, b));
        bus.START = 1'b1;
        bus.MODE  = m;
        bus.A     = a;
        bus.B     = b;
        step();
        bus.START = 1'b0;
        lat = 0;
        busy_cycles = 0;
        while (!bus.DONE && lat < 40) begin
            if (bus.BUSY) busy_cycles++;
            if (disturb && lat == 2) begin
                bus.START = 1'b1;
                bus.MODE  = ~m;
                bus.A     = W'($urandom_range(0, 15));
                bus.B     = W'($urandom_range(1, 15));
            end else begin
                bus.START = 1'b0;
            end
            step();
            lat++;
        end
        bus.START = 1'b0;
        exp = exp_q.pop_front();
        if (lat >= 40) begin
            check_val("done_timeout", 32'(lat), 32'(W));
        end else begin
            // lat counts edges after the START edge.
            check_val("latency", 32'(lat), fast ? 32'd0 : 32'(W));
            check_val("busy_cycles", 32'(busy_cycles), fast ? 32'd0 : 32'(W));
            check_val("busy_at_done", 32'(bus.BUSY), 32'd0);
            check_val("result", 32'(bus.RESULT), 32'(exp));
`ifdef DIV_ZERO_EN
            check_val("err", 32'(bus.ERR), 32'(fast));
`endif
        end
    endtask

    // One quiet cycle after a completion: DONE drops, RESULT holds.
    task automatic idle_cycle();
        logic [2*W-1:0] held;
        held = bus.RESULT;
        step();
        check_val("done_pulse_end", 32'(bus.DONE), 32'd0);
        check_val("result_hold", 32'(bus.RESULT), 32'(held));
        check_val("state_idle", 32'(dbg_state), 32'(IDLE));
    endtask

    // ---------------- stimulus ----------------
    typedef struct packed {
        logic         m;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } op_t;

    op_t plan[6];

    initial begin
        int done_seen;
        plan[0] = '{m: 1'b0, a: 4'hD, b: 4'hB};
        plan[1] = '{m: 1'b0, a: 4'hF, b: 4'hF};
        plan[2] = '{m: 1'b0, a: 4'h0, b: 4'h9};
        plan[3] = '{m: 1'b1, a: 4'hD, b: 4'h3};
        plan[4] = '{m: 1'b1, a: 4'h9, b: 4'hA};
        plan[5] = '{m: 1'b1, a: 4'h9, b: 4'h0};

        RST = 1'b1;
        bus.START = 1'b0;
        bus.MODE  = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        repeat (3) step();
        check_val("rst_busy", 32'(bus.BUSY), 32'd0);
        check_val("rst_done", 32'(bus.DONE), 32'd0);
        check_val("rst_result", 32'(bus.RESULT), 32'd0);
        check_val("rst_state", 32'(dbg_state), 32'(IDLE));
`ifdef DIV_ZERO_EN
        check_val("rst_err", 32'(bus.ERR), 32'd0);
`endif
        RST = 1'b0;
        step();

        foreach (plan[i]) begin
            run_op(plan[i].m, plan[i].a, plan[i].b, 1'b0);
            idle_cycle();
        end

        // START mid-RUN is ignored.
        run_op(1'b0, 4'hD, 4'hB, 1'b1);
        idle_cycle();
        run_op(1'b1, 4'hE, 4'h4, 1'b1);

        // Back-to-back from the FIN cycle, no idle gap.
        run_op(1'b0, 4'h7, 4'h6, 1'b0);
        run_op(1'b1, 4'hF, 4'h2, 1'b0);
        idle_cycle();

        // Reset during RUN cycle 2 aborts with no DONE.
        bus.START = 1'b1;
        bus.MODE  = 1'b0;
        bus.A     = 4'h5;
        bus.B     = 4'h3;
        step();
        bus.START = 1'b0;
        step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        check_val("abort_busy", 32'(bus.BUSY), 32'd0);
        check_val("abort_result", 32'(bus.RESULT), 32'd0);
        check_val("abort_done", 32'(bus.DONE), 32'd0);
        done_seen = 0;
        repeat (6) begin
            step();
            if (bus.DONE) done_seen++;
        end
        check_val("abort_no_done", 32'(done_seen), 32'd0);

        // Random operations, mixing idle gaps and back-to-back issue.
        for (int i = 0; i < 60; i++) begin
            logic         m;
            logic [W-1:0] a;
            logic [W-1:0] b;
            m = 1'($urandom_range(0, 1));
            a = W'($urandom_range(0, 15));
            b = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(0, 15));
            run_op(m, a, b, ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
